// File: rtl/arbiter2_merge.sv
// Two-input round-robin merge into a small output FIFO tagged with the source input.
// Latency: accepted flit visible at Out the next cycle; readies drop while FIFO is full (no pop bypass).
module arbiter2_merge #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic [WIDTH-1:0] In0_data,
  input  logic             In0_valid,
  output logic             In0_ready,
  input  logic [WIDTH-1:0] In1_data,
  input  logic             In1_valid,
  output logic             In1_ready,
  output logic [WIDTH-1:0] Out_data,
  output logic             Out_src,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [CNT_W-1:0] Grant0_cnt,
  output logic [CNT_W-1:0] Grant1_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] dat;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;

  logic   space;
  logic   grant0;
  logic   grant1;
  logic   push;
  logic   pop;
  entry_t push_ent;
  entry_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Space is taken from the registered count only, so a full FIFO never accepts even when popping.
  always_comb begin
    space     = (count_q < DEPTH_C);
    grant0    = In0_valid & (~In1_valid | ~prio_q);
    grant1    = In1_valid & (~In0_valid | prio_q);
    In0_ready = _RESET & space & grant0;
    In1_ready = _RESET & space & grant1;
    push      = In0_ready | In1_ready;
    push_ent.src = In1_ready;
    push_ent.dat = In1_ready ? In1_data : In0_data;
    Out_valid = (count_q != '0);
    pop       = Out_valid & Out_ready;
    head      = Out_valid ? mem_q[rd_ptr_q] : '0;
    Out_data  = head.dat;
    Out_src   = head.src;
    Grant0_cnt = gnt0_cnt_q;
    Grant1_cnt = gnt1_cnt_q;
  end

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    prio_d     = prio_q;
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (In0_ready) begin
      prio_d = 1'b1;
      if (gnt0_cnt_q != '1) gnt0_cnt_d = gnt0_cnt_q + 1'b1;
    end
    if (In1_ready) begin
      prio_d = 1'b0;
      if (gnt1_cnt_q != '1) gnt1_cnt_d = gnt1_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      prio_q     <= 1'b0;
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  a_one_ready: assert property (@(posedge CLK) !(In0_ready && In1_ready));
  a_rdy0_vld:  assert property (@(posedge CLK) In0_ready |-> In0_valid);
  a_rdy1_vld:  assert property (@(posedge CLK) In1_ready |-> In1_valid);
  a_count_max: assert property (@(posedge CLK) count_q <= DEPTH_C);

endmodule

// File: tb/tb_arbiter2_merge.sv
// Randomized plus directed bench for arbiter2_merge, two instances (DEPTH 2 / CNT_W 4 and DEPTH 4 / CNT_W 16).
module tb_arbiter2_merge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, ordy;
  logic [8:0] d0, d1;

  logic       a_r0, a_r1, a_ov, a_os;
  logic [8:0] a_od;
  logic [3:0] a_c0, a_c1;
  logic       b_r0, b_r1, b_ov, b_os;
  logic [8:0] b_od;
  logic [15:0] b_c0, b_c1;

  always #5 clk = ~clk;

  arbiter2_merge #(.WIDTH(9), .DEPTH(2), .CNT_W(4)) dut_a (
    .CLK(clk), ._RESET(rst_n),
    .In0_data(d0), .In0_valid(v0), .In0_ready(a_r0),
    .In1_data(d1), .In1_valid(v1), .In1_ready(a_r1),
    .Out_data(a_od), .Out_src(a_os), .Out_valid(a_ov), .Out_ready(ordy),
    .Grant0_cnt(a_c0), .Grant1_cnt(a_c1)
  );

  arbiter2_merge #(.WIDTH(9), .DEPTH(4), .CNT_W(16)) dut_b (
    .CLK(clk), ._RESET(rst_n),
    .In0_data(d0), .In0_valid(v0), .In0_ready(b_r0),
    .In1_data(d1), .In1_valid(v1), .In1_ready(b_r1),
    .Out_data(b_od), .Out_src(b_os), .Out_valid(b_ov), .Out_ready(ordy),
    .Grant0_cnt(b_c0), .Grant1_cnt(b_c1)
  );

  logic        rdy0_o [2];
  logic        rdy1_o [2];
  logic        ov_o   [2];
  logic        os_o   [2];
  logic [8:0]  od_o   [2];
  logic [15:0] c0_o   [2];
  logic [15:0] c1_o   [2];
  assign rdy0_o[0] = a_r0;  assign rdy0_o[1] = b_r0;
  assign rdy1_o[0] = a_r1;  assign rdy1_o[1] = b_r1;
  assign ov_o[0]   = a_ov;  assign ov_o[1]   = b_ov;
  assign os_o[0]   = a_os;  assign os_o[1]   = b_os;
  assign od_o[0]   = a_od;  assign od_o[1]   = b_od;
  assign c0_o[0]   = {12'd0, a_c0}; assign c0_o[1] = b_c0;
  assign c1_o[0]   = {12'd0, a_c1}; assign c1_o[1] = b_c1;

  // Reference model: one queue per instance, round-robin preference and saturating counts.
  int         dep  [2] = '{2, 4};
  int         cmax [2] = '{15, 65535};
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  logic       m_prio [2];
  int         m_c0 [2];
  int         m_c1 [2];
  logic       e_g0 [2];
  logic       e_g1 [2];
  logic       e_pop [2];
  logic       chk_en;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int         sz;
    logic [9:0] hd;
    logic       sp;
    string      pfx;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pfx = (k == 0) ? "a" : "b";
      hd  = '0;
      if (k == 0) begin
        sz = mq0.size();
        if (sz > 0) hd = mq0[0];
      end else begin
        sz = mq1.size();
        if (sz > 0) hd = mq1[0];
      end
      sp       = rst_n && (sz < dep[k]);
      e_g0[k]  = sp && v0 && (!v1 || !m_prio[k]);
      e_g1[k]  = sp && v1 && (!v0 || m_prio[k]);
      e_pop[k] = (sz != 0) && ordy;
      if (chk_en) begin
        chk({pfx, ".rdy0"}, 32'(rdy0_o[k]), 32'(e_g0[k]));
        chk({pfx, ".rdy1"}, 32'(rdy1_o[k]), 32'(e_g1[k]));
        chk({pfx, ".ovld"}, 32'(ov_o[k]), 32'(sz != 0));
        chk({pfx, ".odat"}, 32'(od_o[k]), 32'(hd[8:0]));
        chk({pfx, ".osrc"}, 32'(os_o[k]), 32'(hd[9]));
        chk({pfx, ".cnt0"}, 32'(c0_o[k]), 32'(m_c0[k]));
        chk({pfx, ".cnt1"}, 32'(c1_o[k]), 32'(m_c1[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        if (k == 0) mq0.delete(); else mq1.delete();
        m_prio[k] = 1'b0;
        m_c0[k]   = 0;
        m_c1[k]   = 0;
      end else begin
        if (e_pop[k]) begin
          if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
        end
        if (e_g0[k]) begin
          if (k == 0) mq0.push_back({1'b0, d0}); else mq1.push_back({1'b0, d0});
          m_prio[k] = 1'b1;
          if (m_c0[k] < cmax[k]) m_c0[k]++;
        end
        if (e_g1[k]) begin
          if (k == 0) mq0.push_back({1'b1, d1}); else mq1.push_back({1'b1, d1});
          m_prio[k] = 1'b0;
          if (m_c1[k] < cmax[k]) m_c1[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ordy = 1'b0;
    chk_en = 1'b0;
    m_prio = '{1'b0, 1'b0};
    m_c0   = '{0, 0};
    m_c1   = '{0, 0};
    step();
    chk_en = 1'b1;
    // Readies must stay low while reset is held, even with requests pending.
    v0 = 1'b1; v1 = 1'b1;
    step();
    chk("rst.ovld", 32'(a_ov), 32'd0);
    chk("rst.odat", 32'(a_od), 32'd0);
    rst_n = 1'b1;

    // Single input
    v0 = 1'b1; v1 = 1'b0; d0 = 9'h1A3; ordy = 1'b1;
    step();
    v0 = 1'b0;
    chk("single.ovld", 32'(a_ov), 32'd1);
    chk("single.odat", 32'(a_od), 32'h1A3);
    chk("single.osrc", 32'(a_os), 32'd0);
    chk("single.cnt0", 32'(a_c0), 32'd1);
    repeat (2) step();

    // Contention
    do_reset();
    v0 = 1'b1; v1 = 1'b1; d0 = 9'h0F0; d1 = 9'h10F; ordy = 1'b1;
    repeat (8) step();
    chk("cont.a_cnt0", 32'(a_c0), 32'd4);
    chk("cont.a_cnt1", 32'(a_c1), 32'd4);
    chk("cont.b_cnt0", 32'(b_c0), 32'd4);
    chk("cont.b_cnt1", 32'(b_c1), 32'd4);

    // Backpressure
    do_reset();
    v0 = 1'b1; v1 = 1'b1; ordy = 1'b0;
    repeat (4) step();
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    repeat (3) step();
    chk("bp.a_cnt0", 32'(a_c0), 32'd2);
    chk("bp.a_cnt1", 32'(a_c1), 32'd1);

    // Pointer wrap
    do_reset();
    v0 = 1'b0; v1 = 1'b1; ordy = 1'b0;
    repeat (30) begin
      d1   = 9'($urandom);
      ordy = ~ordy;
      step();
    end
    v1 = 1'b0; ordy = 1'b1;
    repeat (5) step();

    // Reset mid-stream
    do_reset();
    v0 = 1'b1; v1 = 1'b1; ordy = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid.ovld", 32'(a_ov), 32'd0);
    chk("mid.cnt0", 32'(a_c0), 32'd0);
    step();
    chk("mid.first0", 32'(a_c0), 32'd1);
    chk("mid.first1", 32'(a_c1), 32'd0);

    // Saturation
    do_reset();
    v0 = 1'b1; v1 = 1'b0; ordy = 1'b1;
    repeat (20) begin
      d0 = 9'($urandom);
      step();
    end
    v0 = 1'b0;
    repeat (3) step();
    chk("sat.a_cnt0", 32'(a_c0), 32'd15);
    chk("sat.b_cnt0", 32'(b_c0), 32'd20);

    // Random traffic with occasional resets
    repeat (3000) begin
      rst_n = ($urandom_range(0, 99) != 0);
      v0    = 1'($urandom_range(0, 1));
      v1    = 1'($urandom_range(0, 1));
      d0    = 9'($urandom);
      d1    = 9'($urandom);
      ordy  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
